mult_share_arbiter: RTL and testbench

//   Shares one 8x8 signed sequential multiplier (Start/Done/Product interface) among NREQ requesters.

---
 rtl/mult_share_arbiter.sv | 137 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 signed multiplier among NREQ requesters.
// Latches the winner's operands, starts the multiplier, and returns the product with a one-cycle response.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     Resetn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8-1:0]        mplier_in,
  input  logic [NREQ*8-1:0]        mcand_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic signed [17:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mult_start,
  output logic signed [7:0]        mult_mplier,
  output logic signed [7:0]        mult_mcand,
  input  logic                     mult_done,
  input  logic signed [17:0]       mult_product
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_DONE, CAPTURE, RESP} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [TW-1:0]   timer;
  logic            timed_out;
  logic [PW-1:0]   cand;
  logic            sel_any;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] sel_oh;
  logic [7:0]      sel_mpl;
  logic [7:0]      sel_mcd;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First requester at or above ptr, wrapping around.
  always_comb begin
    cand    = '0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!sel_any && req[cand]) begin
        sel_any = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    sel_oh  = '0;
    sel_mpl = '0;
    sel_mcd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_idx == PW'(k)) begin
        sel_oh[k] = 1'b1;
        sel_mpl   = mplier_in[k*8 +: 8];
        sel_mcd   = mcand_in[k*8 +: 8];
      end
    end
  end

  assign timed_out  = (timer >= TW'(TIMEOUT));
  assign mult_start = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP) ? gnt : '0;

  // A Done still high from the previous op must drop before a new rise is accepted;
  // the timeout covers both waits so a stuck-high Done cannot hang the arbiter either.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (sel_any) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_LOW;
      WAIT_LOW:  if (!mult_done) state_nx = WAIT_DONE;
                 else if (timed_out) state_nx = RESP;
      WAIT_DONE: if (mult_done) state_nx = CAPTURE;
                 else if (timed_out) state_nx = RESP;
      CAPTURE:   state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      ptr         <= '0;
      timer       <= '0;
      rsp_err     <= 1'b0;
      rsp_product <= '0;
      mult_mplier <= '0;
      mult_mcand  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (sel_any) begin
          gnt         <= sel_oh;
          gidx        <= sel_idx;
          mult_mplier <= sel_mpl;
          mult_mcand  <= sel_mcd;
          timer       <= '0;
        end
        WAIT_LOW, WAIT_DONE: begin
          if (!timed_out) timer <= timer + 1'b1;
          if (state_nx == RESP) begin
            rsp_err     <= 1'b1;
            rsp_product <= '0;
          end
        end
        // Done was seen last cycle; the product's final shift has landed by now.
        CAPTURE: rsp_product <= mult_product;
        RESP: begin
          gnt     <= '0;
          rsp_err <= 1'b0;
          ptr     <= wrap_add(gidx, 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a slow sequential multiplier model whose
// Done level lingers into the next op and whose product settles one cycle after Done.
module tb_mult_share_arbiter;

  logic              clk = 1'b0;
  logic              Resetn;
  logic [3:0]        req;
  logic [31:0]       mplier_in, mcand_in;
  logic [3:0]        gnt, rsp_valid;
  logic [17:0]       rsp_product;
  logic              rsp_err, busy, mult_start;
  logic signed [7:0] mult_mplier, mult_mcand;
  logic              mult_done;
  logic signed [17:0] mult_product;

  int total = 0;
  int bad   = 0;

  mult_share_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .Resetn(Resetn), .req(req), .mplier_in(mplier_in), .mcand_in(mcand_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .busy(busy), .mult_start(mult_start), .mult_mplier(mult_mplier), .mult_mcand(mult_mcand),
    .mult_done(mult_done), .mult_product(mult_product)
  );

  always #5 clk = ~clk;

  // Multiplier model: Done drops 3 cycles after start, rises 8 cycles after start,
  // product register updates the cycle after Done rises.
  logic               stuck;
  logic [3:0]         mcnt;
  logic               fin;
  logic signed [17:0] mres;

  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      mult_done    <= 1'b0;
      mult_product <= '0;
      mcnt         <= '0;
      fin          <= 1'b0;
      mres         <= '0;
    end else begin
      fin <= 1'b0;
      if (fin) mult_product <= mres;
      if (mult_start) begin
        mres <= $signed({{10{mult_mplier[7]}}, mult_mplier}) * $signed({{10{mult_mcand[7]}}, mult_mcand});
        mcnt <= 4'd8;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 4'd1;
        if (mcnt == 4'd6) mult_done <= 1'b0;
        if (mcnt == 4'd1 && !stuck) begin
          mult_done <= 1'b1;
          fin       <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Resetn = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    Resetn = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] r, input logic [31:0] mpl, input logic [31:0] mcd,
                        input logic [3:0] eg, input logic [17:0] ep, input logic ee,
                        input string nm, output int ncyc);
    logic [7:0] empl;
    logic       prev_done, got;
    int         rise, starts;
    empl = '0;
    for (int k = 0; k < 4; k++) if (eg[k]) empl = mpl[k*8 +: 8];
    @(negedge clk);
    req = r; mplier_in = mpl; mcand_in = mcd;
    @(posedge clk); #1;
    chk({nm, " grant"}, {28'd0, gnt}, {28'd0, eg});
    chk({nm, " start"}, {31'd0, mult_start}, 32'd1);
    chk({nm, " operand"}, {24'd0, mult_mplier}, {24'd0, empl});
    mplier_in = $urandom; mcand_in = $urandom;
    prev_done = mult_done; got = 1'b0; rise = -1; starts = 0; ncyc = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(posedge clk); #1;
      if (mult_start) starts++;
      if (mult_done && !prev_done) rise = i;
      prev_done = mult_done;
      if (|rsp_valid) begin got = 1'b1; ncyc = i; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s response: none within 200 cycles, required one", nm);
    end else begin
      chk({nm, " rsp_valid"}, {28'd0, rsp_valid}, {28'd0, eg});
      chk({nm, " gnt held"}, {28'd0, gnt}, {28'd0, eg});
      chk({nm, " product"}, {14'd0, rsp_product}, {14'd0, ep});
      chk({nm, " err"}, {31'd0, rsp_err}, {31'd0, ee});
      chk({nm, " extra starts"}, starts, 0);
      if (!ee) chk({nm, " done-to-rsp"}, ncyc - rise, 2);
    end
    req = '0;
    @(posedge clk); #1;
    chk({nm, " pulse len"}, {28'd0, rsp_valid}, 32'd0);
    chk({nm, " idle"}, {27'd0, busy, gnt}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [31:0] mpl;
    logic [31:0] mcd;
    logic [3:0]  eg;
    logic [17:0] ep;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int  ncyc, pulses;
    logic got;
    tbl[0] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 4'b0001, 18'h0000F};
    tbl[1] = '{4'b0010, 32'h0000_FD00, 32'h0000_0500, 4'b0010, 18'h3FFF1};
    tbl[2] = '{4'b0100, 32'h0080_0000, 32'h0080_0000, 4'b0100, 18'h04000};
    tbl[3] = '{4'b1000, 32'h7F00_0000, 32'h8000_0000, 4'b1000, 18'h3C080};
    tbl[4] = '{4'b1010, 32'h1100_FF22, 32'h1100_FF22, 4'b0010, 18'h00001};
    tbl[5] = '{4'b1001, 32'h0A00_0033, 32'hF600_0044, 4'b1000, 18'h3FF9C};
    tbl[6] = '{4'b0101, 32'h0009_0000, 32'h0009_007F, 4'b0001, 18'h00000};

    Resetn = 1'b1; req = '0; mplier_in = '0; mcand_in = '0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset gnt/rsp_valid", {24'd0, gnt, rsp_valid}, 32'd0);
    chk("reset ctrl", {29'd0, busy, mult_start, rsp_err}, 32'd0);
    chk("reset product", {14'd0, rsp_product}, 32'd0);
    chk("reset operands", {16'd0, mult_mplier, mult_mcand}, 32'd0);
    Resetn = 1'b0;

    for (int v = 0; v < 7; v++)
      run_op(tbl[v].r, tbl[v].mpl, tbl[v].mcd, tbl[v].eg, tbl[v].ep, 1'b0, $sformatf("vec%0d", v), ncyc);

    // All four requesting continuously: expect 0,1,2,3,0.
    do_reset();
    @(negedge clk);
    req = 4'b1111; mplier_in = 32'h0403_0201; mcand_in = 32'h0202_0202;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(posedge clk); #1;
        if (|rsp_valid) got = 1'b1;
      end
      if (n == 4) req = '0;
      if (!got) begin
        total++; bad++;
        $display("FAIL rr%0d response: none within 50 cycles, required one", n);
      end else begin
        chk($sformatf("rr%0d order", n), {28'd0, rsp_valid}, {28'd0, 4'(1 << (n % 4))});
        chk($sformatf("rr%0d product", n), {14'd0, rsp_product}, 32'(2 * ((n % 4) + 1)));
      end
    end
    @(posedge clk); #1;
    chk("rr idle", {31'd0, busy}, 32'd0);

    // Back-to-back ops on one requester while Done lingers high from the previous op.
    run_op(4'b0001, 32'h0000_0006, 32'h0000_0007, 4'b0001, 18'h0002A, 1'b0, "stale1", ncyc);
    run_op(4'b0001, 32'h0000_00FE, 32'h0000_0009, 4'b0001, 18'h3FFEE, 1'b0, "stale2", ncyc);

    // Reset in the middle of WAIT_DONE.
    stuck = 1'b1;
    @(negedge clk);
    req = 4'b0010; mplier_in = 32'h0000_0900; mcand_in = 32'h0000_0900;
    repeat (12) @(negedge clk);
    chk("midop busy", {31'd0, busy}, 32'd1);
    #2 Resetn = 1'b1;
    #1;
    chk("midop reset outs", {22'd0, gnt, rsp_valid, busy, mult_start}, 32'd0);
    chk("midop reset data", {14'd0, rsp_product}, 32'd0);
    chk("midop reset operand", {24'd0, mult_mplier}, 32'd0);
    req = '0;
    @(negedge clk);
    Resetn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (|rsp_valid) pulses++;
    end
    chk("midop no response", pulses, 0);
    stuck = 1'b0;
    run_op(4'b0010, 32'h0000_0900, 32'h0000_0900, 4'b0010, 18'h00051, 1'b0, "post-reset", ncyc);

    // Done never rises: error response after the timeout.
    stuck = 1'b1;
    run_op(4'b0100, 32'h0005_0000, 32'h0005_0000, 4'b0100, 18'h00000, 1'b1, "timeout", ncyc);
    chk("timeout window", {31'd0, (ncyc >= 60 && ncyc <= 72)}, 32'd1);
    stuck = 1'b0;
    run_op(4'b0100, 32'h0005_0000, 32'h00FB_0000, 4'b0100, 18'h3FFE7, 1'b0, "after-timeout", ncyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
